// File: rtl/multi_issue_fetch_queue.sv
// Multi-issue instruction fetch front end.
// Fetches FETCH_WIDTH-wide aligned blocks from a 1-cycle-latency instruction memory,
// buffers them in a circular instruction queue and presents up to ISSUE_WIDTH
// in-order instructions (with PCs) to decode. Redirects flush everything in flight.
module multi_issue_fetch_queue #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             imem_req,
    output logic [31:0]                      imem_addr,
    input  logic [32*FETCH_WIDTH-1:0]        imem_rdata,
    input  logic                             redirect_valid,
    input  logic [31:0]                      redirect_target,
    input  logic                             stall,
    output logic [32*ISSUE_WIDTH-1:0]        out_instr,
    output logic [32*ISSUE_WIDTH-1:0]        out_pc,
    output logic [ISSUE_WIDTH-1:0]           out_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);
    localparam int unsigned PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [31:0] BLOCK_MASK = 32'(4 * FETCH_WIDTH - 1);

    logic [31:0]      fetchPc;
    logic [31:0]      inflightPc;
    logic             inflight;
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic [CNT_W-1:0] count;
    logic [31:0]      instrMem [QUEUE_DEPTH];
    logic [31:0]      pcMem    [QUEUE_DEPTH];

    logic [31:0] inflightBase;
    logic [31:0] laneOffset;
    logic [31:0] pushCount;
    logic [31:0] popCount;
    logic [31:0] committed;
    logic        issue;

    // Push/pop amounts and the conservative fetch credit check
    always_comb begin
        inflightBase = inflightPc & ~BLOCK_MASK;
        laneOffset   = (inflightPc >> 2) & 32'(FETCH_WIDTH - 1);
        pushCount    = inflight ? (32'(FETCH_WIDTH) - laneOffset) : '0;
        popCount     = '0;
        if (!stall) begin
            popCount = (32'(count) < 32'(ISSUE_WIDTH)) ? 32'(count) : 32'(ISSUE_WIDTH);
        end
        // An outstanding response is budgeted as a full block even if partly dropped
        committed = 32'(count) + (inflight ? 32'(FETCH_WIDTH) : '0);
        issue     = !redirect_valid && (committed + 32'(FETCH_WIDTH) <= 32'(QUEUE_DEPTH));
    end

    assign imem_req    = issue && !reset;
    assign imem_addr   = fetchPc & ~BLOCK_MASK;
    assign queue_count = count;

    // Present the oldest ISSUE_WIDTH queue entries to decode
    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        out_valid = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            out_instr[32*i +: 32] = instrMem[headPtr + PTR_W'(i)];
            out_pc[32*i +: 32]    = pcMem[headPtr + PTR_W'(i)];
            out_valid[i]          = 32'(count) > i;
        end
    end

    // Fetch PC, in-flight tracking and queue pointers; redirect overrides push and pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc    <= RESET_PC;
            inflightPc <= RESET_PC;
            inflight   <= 1'b0;
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
        end else if (redirect_valid) begin
            fetchPc  <= redirect_target;
            inflight <= 1'b0;
            headPtr  <= '0;
            tailPtr  <= '0;
            count    <= '0;
        end else begin
            assert (32'(count) + pushCount - popCount <= 32'(QUEUE_DEPTH));
            headPtr  <= headPtr + PTR_W'(popCount);
            tailPtr  <= tailPtr + PTR_W'(pushCount);
            count    <= CNT_W'(32'(count) + pushCount - popCount);
            inflight <= issue;
            if (issue) begin
                inflightPc <= fetchPc;
                fetchPc    <= (fetchPc & ~BLOCK_MASK) + 32'(4 * FETCH_WIDTH);
            end
        end
    end

    // Write the response lanes at or above the entry offset into consecutive queue slots
    always_ff @(posedge clk) begin
        if (inflight && !redirect_valid) begin
            for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
                if (k >= laneOffset) begin
                    instrMem[tailPtr + PTR_W'(k - laneOffset)] <= imem_rdata[32*k +: 32];
                    pcMem[tailPtr + PTR_W'(k - laneOffset)]    <= inflightBase + 32'(4 * k);
                end
            end
        end
    end

endmodule
